// File: rtl/yuv_window_calibrator_if.sv
// Pixel stream bundle between the camera pipeline and the calibrator.
//   pix_valid   raw_* and row/col carry a real pixel this cycle
//   sof         start-of-frame pulse
//   row, col    coordinate of the current pixel
//   raw_r/g/b   raw colour channels
// Handshake: one pixel is transferred on every clock edge where pix_valid is
// high; there is no backpressure, so the sink must take every valid pixel.
// master: pixel source (pipeline / bench); slave: the calibrator.
interface yuv_window_calibrator_if #(
   parameter int PIX_W   = 8,
   parameter int COORD_W = 13
);
   logic               pix_valid;
   logic               sof;
   logic [COORD_W-1:0] row;
   logic [COORD_W-1:0] col;
   logic [PIX_W-1:0]   raw_r;
   logic [PIX_W-1:0]   raw_g;
   logic [PIX_W-1:0]   raw_b;

   modport master (output pix_valid, sof, row, col, raw_r, raw_g, raw_b);
   modport slave  (input  pix_valid, sof, row, col, raw_r, raw_g, raw_b);
endinterface

// File: rtl/yuv_window_calibrator.sv
// Averages raw RGB pixels inside a square window of the video stream and
// derives Y/U/V reference values for the colour-threshold logic.
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   start, abort      begin a run from IDLE / cancel the run in progress
//   pix               pixel stream (slave side of yuv_window_calibrator_if)
//   win_row, win_col  window top-left corner, latched at start
//   rgb_yuv           output select: 1 = averaged R,G,B, 0 = Y,U,V
//   y_out/u_out/v_out results (U, V signed in YUV mode)
//   busy, done        not-IDLE flag, one-cycle pulse when results update
//   cal_valid         results valid since the last completed run
//   cal_count         completed runs, wrapping
//   state_dbg         current FSM state, for observation only
module yuv_window_calibrator #(
   parameter int PIX_W    = 8,
   parameter int COORD_W  = 13,
   parameter int WIN_LOG2 = 3,
   parameter int CNT_W    = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   yuv_window_calibrator_if.slave pix,
   input  logic [COORD_W-1:0]     win_row,
   input  logic [COORD_W-1:0]     win_col,
   input  logic                   rgb_yuv,
   output logic [PIX_W-1:0]       y_out,
   output logic [PIX_W:0]         u_out,
   output logic [PIX_W:0]         v_out,
   output logic                   busy,
   output logic                   done,
   output logic                   cal_valid,
   output logic [CNT_W-1:0]       cal_count,
   output logic [1:0]             state_dbg
);
   localparam int SMP_W  = 2 * WIN_LOG2;
   localparam int ACC_W  = PIX_W + SMP_W;
   localparam int WIN    = 1 << WIN_LOG2;
   localparam int PROD_W = PIX_W + 10;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACCUM   = 2'd1;
   localparam logic [1:0] CALC_Y  = 2'd2;
   localparam logic [1:0] CALC_UV = 2'd3;

   localparam logic        [PROD_W-1:0] K_YR = PROD_W'(77);
   localparam logic        [PROD_W-1:0] K_YG = PROD_W'(150);
   localparam logic        [PROD_W-1:0] K_YB = PROD_W'(37);
   localparam logic signed [PROD_W-1:0] K_U  = PROD_W'(126);
   localparam logic signed [PROD_W-1:0] K_V  = PROD_W'(225);

   logic [1:0]         state;
   logic [COORD_W-1:0] wr_q, wc_q;
   logic [ACC_W-1:0]   acc_r, acc_g, acc_b;
   logic [SMP_W-1:0]   smp_cnt;
   logic [PIX_W-1:0]   avg_r_q, avg_g_q, avg_b_q, y_calc_q;
   logic [PIX_W-1:0]   res_r_q, res_g_q, res_b_q, res_y_q;
   logic [PIX_W:0]     res_u_q, res_v_q;

   // Window test at COORD_W+1 bits so a window touching the top of the
   // coordinate range does not wrap its far edge back to zero.
   logic [COORD_W:0] row_x, col_x, wr_x, wc_x, wr_end, wc_end;
   logic             in_win, sample, clear_frame;

   assign row_x  = {1'b0, pix.row};
   assign col_x  = {1'b0, pix.col};
   assign wr_x   = {1'b0, wr_q};
   assign wc_x   = {1'b0, wc_q};
   assign wr_end = wr_x + (COORD_W+1)'(WIN);
   assign wc_end = wc_x + (COORD_W+1)'(WIN);
   assign in_win = (row_x >= wr_x) && (row_x < wr_end) &&
                   (col_x >= wc_x) && (col_x < wc_end);
   assign sample      = pix.pix_valid && in_win;
   assign clear_frame = pix.sof && (smp_cnt != '0);

   // Averages are the top PIX_W bits of each accumulator.
   logic [PIX_W-1:0]  avg_r, avg_g, avg_b;
   logic [PROD_W-1:0] y_sum;
   logic [PIX_W+1:0]  y_hi;
   logic [PIX_W-1:0]  y_sat;

   assign avg_r = PIX_W'(acc_r >> SMP_W);
   assign avg_g = PIX_W'(acc_g >> SMP_W);
   assign avg_b = PIX_W'(acc_b >> SMP_W);
   assign y_sum = K_YR * PROD_W'(avg_r) + K_YG * PROD_W'(avg_g) + K_YB * PROD_W'(avg_b);
   assign y_hi  = (PIX_W+2)'(y_sum >> 8);
   assign y_sat = (|y_hi[PIX_W+1:PIX_W]) ? '1 : y_hi[PIX_W-1:0];

   // Colour differences are at most +/-(2**PIX_W-1), so PIX_W+2 signed bits.
   logic signed [PIX_W+1:0]  diff_b, diff_r;
   logic signed [PROD_W-1:0] diff_b_x, diff_r_x, prod_u, prod_v;
   logic        [PIX_W:0]    u_new, v_new;

   assign diff_b   = $signed({2'b00, avg_b_q}) - $signed({2'b00, y_calc_q});
   assign diff_r   = $signed({2'b00, avg_r_q}) - $signed({2'b00, y_calc_q});
   assign diff_b_x = {{(PROD_W-PIX_W-2){diff_b[PIX_W+1]}}, diff_b};
   assign diff_r_x = {{(PROD_W-PIX_W-2){diff_r[PIX_W+1]}}, diff_r};
   assign prod_u   = diff_b_x * K_U;
   assign prod_v   = diff_r_x * K_V;
   // Arithmetic shift of a two's-complement product rounds toward -inf.
   assign u_new    = (PIX_W+1)'(prod_u >>> 8);
   assign v_new    = (PIX_W+1)'(prod_v >>> 8);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wr_q      <= '0;
         wc_q      <= '0;
         acc_r     <= '0;
         acc_g     <= '0;
         acc_b     <= '0;
         smp_cnt   <= '0;
         avg_r_q   <= '0;
         avg_g_q   <= '0;
         avg_b_q   <= '0;
         y_calc_q  <= '0;
         res_r_q   <= '0;
         res_g_q   <= '0;
         res_b_q   <= '0;
         res_y_q   <= '0;
         res_u_q   <= '0;
         res_v_q   <= '0;
         cal_valid <= 1'b0;
         cal_count <= '0;
      end else if (abort) begin
         // Abort beats everything, including the result-update cycle.
         state     <= IDLE;
         cal_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= ACCUM;
                  cal_valid <= 1'b0;
                  acc_r     <= '0;
                  acc_g     <= '0;
                  acc_b     <= '0;
                  smp_cnt   <= '0;
                  wr_q      <= win_row;
                  wc_q      <= win_col;
               end
            end
            ACCUM: begin
               if (clear_frame) begin
                  // New frame: a coincident sample becomes its first sample.
                  acc_r   <= sample ? ACC_W'(pix.raw_r) : '0;
                  acc_g   <= sample ? ACC_W'(pix.raw_g) : '0;
                  acc_b   <= sample ? ACC_W'(pix.raw_b) : '0;
                  smp_cnt <= sample ? SMP_W'(1) : '0;
               end else if (sample) begin
                  acc_r   <= acc_r + ACC_W'(pix.raw_r);
                  acc_g   <= acc_g + ACC_W'(pix.raw_g);
                  acc_b   <= acc_b + ACC_W'(pix.raw_b);
                  smp_cnt <= smp_cnt + SMP_W'(1);
                  if (smp_cnt == '1) state <= CALC_Y;
               end
            end
            CALC_Y: begin
               avg_r_q  <= avg_r;
               avg_g_q  <= avg_g;
               avg_b_q  <= avg_b;
               y_calc_q <= y_sat;
               state    <= CALC_UV;
            end
            CALC_UV: begin
               res_r_q   <= avg_r_q;
               res_g_q   <= avg_g_q;
               res_b_q   <= avg_b_q;
               res_y_q   <= y_calc_q;
               res_u_q   <= u_new;
               res_v_q   <= v_new;
               cal_valid <= 1'b1;
               cal_count <= cal_count + CNT_W'(1);
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == CALC_UV) && !abort && !reset;
   assign state_dbg = state;
   assign y_out     = rgb_yuv ? res_r_q : res_y_q;
   assign u_out     = rgb_yuv ? {1'b0, res_g_q} : res_u_q;
   assign v_out     = rgb_yuv ? {1'b0, res_b_q} : res_v_q;
endmodule

// File: tb/tb_yuv_window_calibrator.sv
// Directed bench for yuv_window_calibrator with hand-computed expected values.
module tb_yuv_window_calibrator;
   localparam int PIX_W = 8, COORD_W = 13, WIN_LOG2 = 3, CNT_W = 5;

   logic               clk = 1'b0;
   logic               reset, start, abort, rgb_yuv;
   logic [COORD_W-1:0] win_row, win_col;
   logic [PIX_W-1:0]   y_out;
   logic [PIX_W:0]     u_out, v_out;
   logic               busy, done, cal_valid;
   logic [CNT_W-1:0]   cal_count;
   logic [1:0]         state_dbg;

   yuv_window_calibrator_if #(.PIX_W(PIX_W), .COORD_W(COORD_W)) pix_if ();

   yuv_window_calibrator #(
      .PIX_W(PIX_W), .COORD_W(COORD_W), .WIN_LOG2(WIN_LOG2), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .pix(pix_if),
      .win_row(win_row), .win_col(win_col), .rgb_yuv(rgb_yuv),
      .y_out(y_out), .u_out(u_out), .v_out(v_out), .busy(busy), .done(done),
      .cal_valid(cal_valid), .cal_count(cal_count), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset / monitors ----------------
   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0, exp_done = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_yuv(input string t, input logic [7:0] ey, input logic [8:0] eu, input logic [8:0] ev);
      rgb_yuv = 1'b0; #1;
      check({t, "_y"}, 32'(y_out), 32'(ey));
      check({t, "_u"}, 32'(u_out), 32'(eu));
      check({t, "_v"}, 32'(v_out), 32'(ev));
   endtask

   task automatic check_rgb(input string t, input logic [7:0] er, input logic [8:0] eg, input logic [8:0] eb);
      rgb_yuv = 1'b1; #1;
      check({t, "_r"}, 32'(y_out), 32'(er));
      check({t, "_g"}, 32'(u_out), 32'(eg));
      check({t, "_b"}, 32'(v_out), 32'(eb));
      rgb_yuv = 1'b0; #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive_px(input logic v, input logic s, input logic [12:0] r, input logic [12:0] c,
                           input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
      pix_if.pix_valid = v; pix_if.sof = s; pix_if.row = r; pix_if.col = c;
      pix_if.raw_r = rr; pix_if.raw_g = gg; pix_if.raw_b = bb;
      tick();
   endtask

   task automatic start_run(input logic [12:0] wr, input logic [12:0] wc);
      win_row = wr; win_col = wc; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Samples first..first+cnt-1 of the 8x8 window in raster order, all valid.
   task automatic feed_block(input logic [12:0] wr, input logic [12:0] wc,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input int first, input int cnt, input bit sof_first);
      for (int i = first; i < first + cnt; i++) begin
         last_cyc = cyc;
         drive_px(1'b1, sof_first && (i == first), wr + 13'(i / 8), wc + 13'(i % 8), r, g, b);
      end
      pix_if.pix_valid = 1'b0; pix_if.sof = 1'b0;
   endtask

   // 10x10 raster around the window; the one-pixel border carries 255s.
   // With toggle set, each pixel is preceded by an invalid cycle of 255s.
   task automatic sweep(input logic [12:0] wr, input logic [12:0] wc,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit toggle);
      for (int dr = -1; dr <= 8; dr++) begin
         for (int dc = -1; dc <= 8; dc++) begin
            bit inw;
            inw = (dr >= 0) && (dr < 8) && (dc >= 0) && (dc < 8);
            if (toggle) drive_px(1'b0, 1'b0, wr + 13'(dr), wc + 13'(dc), 8'hFF, 8'hFF, 8'hFF);
            if (inw) last_cyc = cyc;
            drive_px(1'b1, 1'b0, wr + 13'(dr), wc + 13'(dc),
                     inw ? r : 8'hFF, inw ? g : 8'hFF, inw ? b : 8'hFF);
         end
      end
      pix_if.pix_valid = 1'b0;
   endtask

   task automatic wait_idle(input string t);
      int n;
      pix_if.pix_valid = 1'b0; pix_if.sof = 1'b0;
      n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      check({t, "_timeout"}, 32'(busy), 32'd0);
   endtask

   task automatic check_zero(input string t);
      check_yuv(t, 8'd0, 9'd0, 9'd0);
      check_rgb(t, 8'd0, 9'd0, 9'd0);
      check({t, "_busy"}, 32'(busy), 32'd0);
      check({t, "_done"}, 32'(done), 32'd0);
      check({t, "_valid"}, 32'(cal_valid), 32'd0);
      check({t, "_count"}, 32'(cal_count), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; rgb_yuv = 1'b0;
      win_row = '0; win_col = '0;
      pix_if.pix_valid = 1'b0; pix_if.sof = 1'b0; pix_if.row = '0; pix_if.col = '0;
      pix_if.raw_r = '0; pix_if.raw_g = '0; pix_if.raw_b = '0;
      repeat (3) tick();
      check_zero("reset");
      reset = 1'b0;
      tick();

      // Grey 100: Y=103, U=-2, V=-3; two-cycle latency to done
      start_run(13'd10, 13'd20);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_state", 32'(state_dbg), 32'd1);
      sweep(13'd10, 13'd20, 8'd100, 8'd100, 8'd100, 1'b0);
      wait_idle("t1");
      exp_done++;
      check("t1_done_cnt", 32'(done_cnt), 32'(exp_done));
      check("t1_latency", 32'(done_cyc - last_cyc), 32'd2);
      check("t1_valid", 32'(cal_valid), 32'd1);
      check("t1_count", 32'(cal_count), 32'd1);
      check_yuv("t1", 8'd103, 9'h1FE, 9'h1FD);
      check_rgb("t1", 8'd100, 9'd100, 9'd100);

      // Same pixels with pix_valid toggling: results unchanged
      start_run(13'd10, 13'd20);
      check("t2_valid_clr", 32'(cal_valid), 32'd0);
      check("t2_hold_y", 32'(y_out), 32'd103);
      sweep(13'd10, 13'd20, 8'd100, 8'd100, 8'd100, 1'b1);
      wait_idle("t2");
      exp_done++;
      check("t2_done_cnt", 32'(done_cnt), 32'(exp_done));
      check_yuv("t2", 8'd103, 9'h1FE, 9'h1FD);
      check("t2_count", 32'(cal_count), 32'd2);

      // Pure red 200: Y=60, U=-30, V=123
      start_run(13'd10, 13'd20);
      sweep(13'd10, 13'd20, 8'd200, 8'd0, 8'd0, 1'b0);
      wait_idle("t3");
      exp_done++;
      check_yuv("t3", 8'd60, 9'h1E2, 9'h07B);
      check_rgb("t3", 8'd200, 9'd0, 9'd0);
      check("t3_count", 32'(cal_count), 32'd3);

      // sof after 40 stale samples; sof coincides with the first fresh one
      start_run(13'd10, 13'd20);
      feed_block(13'd10, 13'd20, 8'd0, 8'd255, 8'd255, 0, 40, 1'b0);
      feed_block(13'd10, 13'd20, 8'd100, 8'd100, 8'd100, 0, 64, 1'b1);
      wait_idle("t4");
      exp_done++;
      check("t4_done_cnt", 32'(done_cnt), 32'(exp_done));
      check_yuv("t4", 8'd103, 9'h1FE, 9'h1FD);
      check("t4_count", 32'(cal_count), 32'd4);

      // abort on the CALC_UV cycle
      start_run(13'd10, 13'd20);
      feed_block(13'd10, 13'd20, 8'd200, 8'd0, 8'd0, 0, 64, 1'b0);
      check("t5_state_y", 32'(state_dbg), 32'd2);
      tick();
      check("t5_state_uv", 32'(state_dbg), 32'd3);
      abort = 1'b1; #1;
      check("t5_done_gated", 32'(done), 32'd0);
      tick();
      abort = 1'b0;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_valid", 32'(cal_valid), 32'd0);
      check("t5_count", 32'(cal_count), 32'd4);
      check("t5_done_cnt", 32'(done_cnt), 32'(exp_done));
      check_yuv("t5_hold", 8'd103, 9'h1FE, 9'h1FD);

      // start while busy is ignored; window stays latched
      start_run(13'd10, 13'd20);
      feed_block(13'd10, 13'd20, 8'd200, 8'd0, 8'd0, 0, 30, 1'b0);
      start_run(13'd0, 13'd0);
      feed_block(13'd10, 13'd20, 8'd200, 8'd0, 8'd0, 30, 34, 1'b0);
      wait_idle("t6");
      exp_done++;
      check_yuv("t6", 8'd60, 9'h1E2, 9'h07B);
      check("t6_count", 32'(cal_count), 32'd5);

      // Window at the top of the coordinate range
      start_run(13'd8184, 13'd8184);
      feed_block(13'd8184, 13'd8184, 8'd100, 8'd100, 8'd100, 0, 64, 1'b0);
      wait_idle("t7");
      exp_done++;
      check_yuv("t7", 8'd103, 9'h1FE, 9'h1FD);

      // White: Y would be 262, saturates to 255
      start_run(13'd8184, 13'd8184);
      feed_block(13'd8184, 13'd8184, 8'd255, 8'd255, 8'd255, 0, 64, 1'b0);
      wait_idle("t8");
      exp_done++;
      check_yuv("t8", 8'd255, 9'd0, 9'd0);
      check("t8_count", 32'(cal_count), 32'd7);
      check("t8_done_cnt", 32'(done_cnt), 32'(exp_done));

      // 33 runs from reset: cal_count wraps to 1
      reset = 1'b1; tick(); reset = 1'b0;
      check("t9_count_rst", 32'(cal_count), 32'd0);
      for (int k = 0; k < 33; k++) begin
         start_run(13'd10, 13'd20);
         feed_block(13'd10, 13'd20, 8'd100, 8'd100, 8'd100, 0, 64, 1'b0);
         wait_idle("t9");
         exp_done++;
      end
      check("t9_count_wrap", 32'(cal_count), 32'd1);
      check("t9_done_cnt", 32'(done_cnt), 32'(exp_done));
      check_yuv("t9", 8'd103, 9'h1FE, 9'h1FD);

      // reset mid-ACCUM
      start_run(13'd10, 13'd20);
      feed_block(13'd10, 13'd20, 8'd100, 8'd100, 8'd100, 0, 20, 1'b0);
      reset = 1'b1;
      tick();
      check_zero("t10");
      reset = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
